// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port among three writeback requesters.
// Define REGWR_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority (0 highest).
module regfile_write_arbiter #(
  parameter int NREQ       = 3,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rf_wr_en,
  output logic [ADDR_W-1:0]        rf_wr_addr,
  output logic [DATA_W-1:0]        rf_wr_data,
  output logic [NREQ-1:0]          starve,
  output logic [1:0]               grant_id
);
  logic [1:0]        win;
  logic [1:0]        cand;
  logic              hit;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [3:0]        wait_cnt [NREQ];
  logic [3:0]        wait_nxt [NREQ];
  logic [NREQ-1:0]   starve_nxt;
`ifdef REGWR_ARB_ROUND_ROBIN_EN
  logic [1:0]        rr_ptr;
  logic [2:0]        rot;
`endif
  // Scan from lowest to highest priority so the highest-priority valid wins last.
  always_comb begin
    win = '0;
    hit = 1'b0;
    cand = '0;
`ifdef REGWR_ARB_ROUND_ROBIN_EN
    rot = '0;
`endif
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef REGWR_ARB_ROUND_ROBIN_EN
      rot = {1'b0, rr_ptr} + 3'(k);
      cand = rot >= 3'(NREQ) ? 2'(rot - 3'(NREQ)) : rot[1:0];
`else
      cand = 2'(k);
`endif
      if (req_valid[cand]) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end
  assign xfer      = hit & reset_n;
  assign req_ready = xfer ? NREQ'(1) << win : '0;
  assign win_addr  = req_addr[win*ADDR_W +: ADDR_W];
  assign win_data  = req_data[win*DATA_W +: DATA_W];
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wait_nxt[i] = (!req_valid[i] || req_ready[i]) ? 4'd0 : wait_cnt[i] + {3'd0, wait_cnt[i] != 4'd15};
      starve_nxt[i] = wait_nxt[i] >= 4'(STARVE_LIM);
    end
  end
  // Writes to register 0 complete the handshake but never reach the register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      starve     <= '0;
      grant_id   <= 2'd3;
      wait_cnt   <= '{default: 4'd0};
`ifdef REGWR_ARB_ROUND_ROBIN_EN
      rr_ptr     <= 2'd0;
`endif
    end else begin
      rf_wr_en <= xfer && win_addr != '0;
      wait_cnt <= wait_nxt;
      starve   <= starve_nxt;
      if (xfer && win_addr != '0) begin
        rf_wr_addr <= win_addr;
        rf_wr_data <= win_data;
      end
      if (xfer) begin
        grant_id <= win;
`ifdef REGWR_ARB_ROUND_ROBIN_EN
        rr_ptr   <= win == 2'(NREQ - 1) ? 2'd0 : win + 2'd1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: randomized bench checking the write arbiter against a queue-free behavioural model.
module tb_regfile_write_arbiter;
  localparam int LIM = 8;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] req_valid = '0;
  logic [8:0] req_addr = '0;
  logic [23:0] req_data = '0;
  logic [2:0] req_ready;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic [2:0] starve;
  logic [1:0] grant_id;

  regfile_write_arbiter #(.NREQ(3), .DATA_W(8), .ADDR_W(3), .STARVE_LIM(LIM)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .starve(starve), .grant_id(grant_id));

  always #5 clock = ~clock;

  int pass_n = 0;
  int tot_n = 0;
  int m_rr, m_gid, m_w;
  logic m_en;
  logic [2:0] m_addr, m_starve;
  logic [7:0] m_data;
  int m_wait [3];
  bit rel = 0;
  logic [2:0] cv;
  logic [2:0] ca [3];
  logic [7:0] cd [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_en = 0; m_addr = 0; m_data = 0; m_starve = 0; m_gid = 3; m_rr = 0; m_w = -1;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
  endtask

  function automatic int winner(input logic [2:0] v);
    int start;
`ifdef REGWR_ARB_ROUND_ROBIN_EN
    start = m_rr;
`else
    start = 0;
`endif
    for (int off = 0; off < 3; off++)
      if (v[(start + off) % 3]) return (start + off) % 3;
    return -1;
  endfunction

  task automatic apply(input logic [2:0] v, input logic [8:0] a, input logic [23:0] d);
    @(negedge clock);
    if (rel) begin reset_n = 1'b1; rel = 0; end
    req_valid = v; req_addr = a; req_data = d;
    #1;
    m_w = reset_n ? winner(v) : -1;
    chk("ready", req_ready, m_w < 0 ? 3'b000 : 3'b001 << m_w);
    chk("wr_en", rf_wr_en, m_en);
    if (m_en) begin
      chk("wr_addr", rf_wr_addr, m_addr);
      chk("wr_data", rf_wr_data, m_data);
    end
    chk("grant_id", grant_id, m_gid);
    chk("starve", starve, m_starve);
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) return;
    for (int i = 0; i < 3; i++) begin
      m_wait[i] = (req_valid[i] && i != m_w) ? (m_wait[i] < 15 ? m_wait[i] + 1 : 15) : 0;
      m_starve[i] = m_wait[i] >= LIM;
    end
    m_en = 0;
    if (m_w >= 0) begin
      m_gid = m_w;
      m_rr = (m_w + 1) % 3;
      if (req_addr[m_w*3 +: 3] != 0) begin
        m_en = 1;
        m_addr = req_addr[m_w*3 +: 3];
        m_data = req_data[m_w*8 +: 8];
      end
    end
  endtask

  initial begin
    model_reset();
    apply(3'b111, 9'o777, 24'h123456);
    tick();
    apply(3'b111, 9'o777, 24'h123456);
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_en", rf_wr_en, 1'b0);
    chk("rst_gid", grant_id, 2'd3);
    chk("rst_starve", starve, 3'b000);
    tick();
    rel = 1;
    apply(3'b111, 9'o123, 24'h010203);
    chk("first_grant", req_ready, 3'b001);
    tick();
    apply(3'b010, 9'o050, 24'h00A700);
    tick();
    apply(3'b000, 9'o000, 24'h0);
    chk("single_en", rf_wr_en, 1'b1);
    chk("single_addr", rf_wr_addr, 3'd5);
    chk("single_data", rf_wr_data, 8'hA7);
    chk("single_gid", grant_id, 2'd1);
    tick();
    apply(3'b100, 9'o000, 24'hFF0000);
    chk("r0_en_idle", rf_wr_en, 1'b0);
    chk("r0_ready", req_ready, 3'b100);
    tick();
    apply(3'b000, 9'o000, 24'h0);
    chk("r0_en", rf_wr_en, 1'b0);
    chk("r0_gid", grant_id, 2'd2);
    tick();
`ifdef REGWR_ARB_ROUND_ROBIN_EN
    for (int c = 0; c < 7; c++) begin
      apply(c < 6 ? 3'b111 : 3'b000, 9'o321, 24'h332211);
      if (c < 6) chk("rr_order", req_ready, 3'b001 << (c % 3));
      if (c > 0) chk("rr_en", rf_wr_en, 1'b1);
      chk("rr_starve", starve, 3'b000);
      tick();
    end
`else
    for (int c = 1; c <= 11; c++) begin
      apply(c <= 10 ? 3'b101 : 3'b000, 9'o703, 24'h990011);
      if (c <= 10) chk("fp_ready", req_ready, 3'b001);
      if (c == 8) chk("fp_starve7", starve, 3'b000);
      if (c == 9) chk("fp_starve8", starve, 3'b100);
      tick();
    end
`endif
    apply(3'b001, 9'o003, 24'h00005A);
    tick();
    @(negedge clock);
    chk("ar_en_before", rf_wr_en, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("ar_en", rf_wr_en, 1'b0);
    chk("ar_gid", grant_id, 2'd3);
    chk("ar_starve", starve, 3'b000);
    chk("ar_ready", req_ready, 3'b000);
    model_reset();
    rel = 1;
    cv = '0;
    for (int i = 0; i < 3; i++) begin ca[i] = '0; cd[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++)
        if (!(cv[i] && i != m_w && reset_n)) begin
          cv[i] = $urandom_range(0, 99) < 65;
          ca[i] = 3'($urandom_range(0, 7));
          cd[i] = 8'($urandom_range(0, 255));
        end
      apply(cv, {ca[2], ca[1], ca[0]}, {cd[2], cd[1], cd[0]});
      tick();
      if (c == 300) begin
        #3 reset_n = 1'b0;
        #1 chk("ar_rand_en", rf_wr_en, 1'b0);
        model_reset();
        rel = 1;
      end
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 8 x 8-bit register file among three writeback requesters: ALU result, memory load and immediate load. Each cycle it grants at most one requester with a valid/ready handshake and registers the winning address/data onto the register file's write inputs. Writes to register 0 are consumed but never forwarded, so register 0 stays zero. Per-requester wait counters flag starvation for debug and performance monitoring.

## Interface
- NREQ, 3, number of requesters (fixed at 3; not a supported override)
- DATA_W, 8, write data width
- ADDR_W, 3, register address width
- STARVE_LIM, 8, consecutive waiting cycles before `starve[i]` asserts (1..15)

- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a write pending; must hold with addr/data until accepted
- req_addr  in  NREQ*ADDR_W  destination register, slice i = bits [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  write data, slice i = bits [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot or zero; combinational grant for this cycle
- rf_wr_en  out  1  registered; drives register file RegWrite
- rf_wr_addr  out  ADDR_W  registered; drives register file EscReg
- rf_wr_data  out  DATA_W  registered; drives register file WriteData
- starve  out  NREQ  registered; requester i has waited >= STARVE_LIM consecutive cycles
- grant_id  out  2  registered; index of the last accepted requester (3 = none since reset)

## Operation
- Grant logic is combinational over `req_valid` and the priority state. `req_ready[i]=1` only for the winner.
- A transfer occurs when `req_valid[i] & req_ready[i]`. `req_valid` must never depend on `req_ready`.
- Accepted write with `addr != 0`: `rf_wr_en`, `rf_wr_addr` and `rf_wr_data` load the winner's values at the next edge.
- Accepted write with `addr == 0`: handshake completes, but `rf_wr_en` loads 0. `grant_id` still updates.
- No transfer: `rf_wr_en` loads 0. `rf_wr_addr` and `rf_wr_data` hold their previous values.
- Priority state `rr_ptr` (2 bits, values 0..2): the search starts at `rr_ptr` and wraps 2→0. After a transfer, `rr_ptr` = winner+1 mod 3. With no transfer, `rr_ptr` holds.
- Wait counter `wait_cnt[i]` (4 bits, saturating at 15):
  - cleared when requester i transfers or `req_valid[i]=0`;
  - incremented when `req_valid[i]=1` and requester i is not granted.
- `starve[i]` is registered as `wait_cnt_next[i] >= STARVE_LIM`.
- Same destination from two requesters in one cycle: only the winner writes; the loser retries next cycle. Register file order follows grant order.
- Reset values: `rf_wr_en=0`, `rf_wr_addr=0`, `rf_wr_data=0`, `starve=0`, `grant_id=3`, `rr_ptr=0`, all `wait_cnt=0`.
- Reset mid-operation: any write not yet driven on `rf_wr_en` is discarded. Requesters must re-present it after reset.

## Timing
- Latency: handshake on edge k → `rf_wr_en` high during cycle k..k+1 → register file writes on edge k+1.
- Throughput: one accepted write per cycle, back-to-back, with no bubbles.
- `req_ready` is valid the same cycle as `req_valid` (combinational path valid→ready, no path ready→valid).
- `starve` and `grant_id` lag the causing event by one cycle.
- `reset_n` assertion takes effect immediately, without waiting for a clock edge. Deassertion is synchronised externally to `clock`.

## Configuration
- `REGWR_ARB_ROUND_ROBIN_EN` defined: round-robin grant using `rr_ptr`, as described above.
- Undefined: fixed priority; requester 0 is highest and 2 is lowest. `rr_ptr` is not implemented. Starvation flags remain active, and this is the configuration where they are expected to fire.

## Test plan
- Reset: hold `reset_n=0` with all valids high → `req_ready=000`, `rf_wr_en=0`, `grant_id=3`, `starve=000`. Release → first grant goes to requester 0.
- Single write: req1 valid, addr=5, data=8'hA7 at edge k → `rf_wr_en=1`, `rf_wr_addr=5`, `rf_wr_data=A7` after edge k, low after edge k+1 if idle.
- Round robin (macro defined): all three valid continuously for 6 cycles → grant order 0,1,2,0,1,2, `rf_wr_en` high every cycle, `starve=000`.
- Fixed priority (macro undefined), STARVE_LIM=8: req0 and req2 valid for 10 cycles → req0 granted every cycle; `starve[2]=1` from the cycle after its 8th wait.
- Register 0: req2 addr=0, data=8'hFF → `req_ready[2]=1`, `rf_wr_en` stays 0, `grant_id=2`.
- Async reset mid-burst: assert `reset_n` low between edges while `rf_wr_en=1` → `rf_wr_en` drops to 0 immediately and `wait_cnt` clears.
